// File: rtl/mmio_arb_pkg.sv
// Shared definitions for the two-master MMIO arbiter: FSM encodings, op type
// and the default read data returned when the slave never answers.
package mmio_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  localparam logic [31:0] MMIO_ERR_DATA = 32'hDEAD_BEEF;

  // A master raising read and write together is serviced as a write.
  function automatic op_t req_op(input logic write);
    return write ? OP_WRITE : OP_READ;
  endfunction

endpackage

// File: rtl/mmio_arb_rr.sv
// Combinational two-way round-robin picker; `last` names the master that
// owned the previous transaction and loses a tie.
module mmio_arb_rr (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       valid
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  assign valid = |req;

endmodule

// File: rtl/mmio_arbiter.sv
// Shares one MMIO slave port between two masters, one registered transaction
// at a time, with a watchdog that error-completes unanswered accesses.
//
// state   | meaning
// IDLE    | arbitrate; latch the winner's address, data and op
// BUSY    | slave request held; watchdog counting
// RESP    | one-cycle ack (with data/err) to the granted master
module mmio_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = MMIO_ERR_DATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_data,
  output logic [31:0] m0_dataOut,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_data,
  output logic [31:0] m1_dataOut,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_address,
  output logic [31:0] s_data,
  input  logic [31:0] s_dataOut,
  input  logic        s_ack,
  output logic [1:0]  grant
);

  localparam int             WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t          state;
  logic            last;
  logic [WD_W-1:0] wdog;

  logic [1:0]  pick_gnt;
  logic        pick_valid;
  op_t         pick_op;
  logic [31:0] rsp_data;

  mmio_arb_rr u_rr (
    .req   ({m1_read | m1_write, m0_read | m0_write}),
    .last  (last),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  assign pick_op  = req_op(pick_gnt[1] ? m1_write : m0_write);
  assign rsp_data = s_ack ? s_dataOut : ERR_DATA;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      last       <= 1'b1;
      wdog       <= '0;
      grant      <= 2'b00;
      s_read     <= 1'b0;
      s_write    <= 1'b0;
      s_address  <= '0;
      s_data     <= '0;
      m0_ack     <= 1'b0;
      m0_err     <= 1'b0;
      m0_dataOut <= '0;
      m1_ack     <= 1'b0;
      m1_err     <= 1'b0;
      m1_dataOut <= '0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant     <= pick_gnt;
            s_address <= pick_gnt[1] ? m1_address : m0_address;
            s_data    <= pick_gnt[1] ? m1_data : m0_data;
            s_write   <= (pick_op == OP_WRITE);
            s_read    <= (pick_op == OP_READ);
            wdog      <= '0;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // s_ack beats the watchdog when both land on the same cycle.
          if (s_ack || (wdog == WD_LAST)) begin
            s_read  <= 1'b0;
            s_write <= 1'b0;
            if (grant[1]) begin
              m1_ack     <= 1'b1;
              m1_err     <= ~s_ack;
              m1_dataOut <= rsp_data;
            end else begin
              m0_ack     <= 1'b1;
              m0_err     <= ~s_ack;
              m0_dataOut <= rsp_data;
            end
            state <= ST_RESP;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        ST_RESP: begin
          last  <= grant[1];
          grant <= 2'b00;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_arbiter.sv
// Scoreboard bench for mmio_arbiter: queued master requests, a scripted slave
// and expected slave/master transactions compared as the DUT produces them.
module tb_mmio_arbiter;

  localparam int          TIMEOUT  = 8;
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_read = 1'b0, m0_write = 1'b0;
  logic [31:0] m0_address = '0, m0_data = '0, m0_dataOut;
  logic        m0_ack, m0_err;
  logic        m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m1_address = '0, m1_data = '0, m1_dataOut;
  logic        m1_ack, m1_err;
  logic        s_read, s_write;
  logic [31:0] s_address, s_data;
  logic [31:0] s_dataOut = '0;
  logic        s_ack = 1'b0;
  logic [1:0]  grant;

  mmio_arbiter #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_WORD)) dut (
    .clk(clk), .rst(rst),
    .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
    .m0_data(m0_data), .m0_dataOut(m0_dataOut), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
    .m1_data(m1_data), .m1_dataOut(m1_dataOut), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_read(s_read), .s_write(s_write), .s_address(s_address), .s_data(s_data),
    .s_dataOut(s_dataOut), .s_ack(s_ack), .grant(grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } mreq_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        chk_data;
  } mrsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
    logic [1:0]  gnt;
    int          delay;   // BUSY cycle index of s_ack; negative = never
    int          len;
    logic [31:0] rdata;
  } sexp_t;

  mreq_t mreq0[$], mreq1[$];
  mrsp_t exp_m0[$], exp_m1[$];
  sexp_t exp_s[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- stimulus / expectation builders ----------------
  task automatic push_req(input int m, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data);
    mreq_t r;
    r.rd = rd; r.wr = wr; r.addr = addr; r.data = data;
    if (m == 0) mreq0.push_back(r); else mreq1.push_back(r);
  endtask

  task automatic push_slave(input int m, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input int delay, input logic [31:0] rdata);
    sexp_t s;
    s.addr = addr; s.data = data; s.wr = wr;
    s.gnt = (m == 0) ? 2'b01 : 2'b10;
    s.delay = delay;
    s.len = (delay < 0) ? TIMEOUT : delay + 1;
    s.rdata = rdata;
    exp_s.push_back(s);
  endtask

  task automatic push_rsp(input int m, input logic [31:0] data, input logic err, input logic chk);
    mrsp_t r;
    r.data = data; r.err = err; r.chk_data = chk;
    if (m == 0) exp_m0.push_back(r); else exp_m1.push_back(r);
  endtask

  task automatic issue(input int m, input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input int delay, input logic [31:0] rdata);
    push_req(m, rd, wr, addr, data);
    push_slave(m, wr, addr, data, delay, rdata);
    if (delay < 0) push_rsp(m, ERR_WORD, 1'b1, 1'b1);
    else           push_rsp(m, rdata, 1'b0, ~wr);
  endtask

  // ---------------- slave model, response checker, master drivers ----------------
  sexp_t cur;
  logic  cur_valid = 1'b0;
  int    cnt = 0, cyc = 0, start_cyc = 0;

  task automatic ack_seen(input int m);
    mrsp_t       r;
    logic [31:0] dout;
    logic        err;
    int          sz;
    if (m == 0) begin sz = exp_m0.size(); dout = m0_dataOut; err = m0_err; end
    else        begin sz = exp_m1.size(); dout = m1_dataOut; err = m1_err; end
    if (m == 0) check_eq("m0_ack_expected", 32'(sz != 0), 32'd1);
    else        check_eq("m1_ack_expected", 32'(sz != 0), 32'd1);
    if (sz == 0) return;
    if (m == 0) r = exp_m0.pop_front(); else r = exp_m1.pop_front();
    check_eq("m_err", 32'(err), 32'(r.err));
    if (r.chk_data) check_eq("m_dataOut", dout, r.data);
    if (cur_valid) check_eq("ack_latency", 32'(cyc - start_cyc), 32'(cur.len));
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      cnt = 0;
      s_ack = 1'b0;
      cur_valid = 1'b0;
    end else if (s_read || s_write) begin
      if (cnt == 0) begin
        check_eq("s_q_nonempty", 32'(exp_s.size() != 0), 32'd1);
        if (exp_s.size() != 0) begin
          cur = exp_s.pop_front();
          cur_valid = 1'b1;
        end
        start_cyc = cyc;
      end
      if (cur_valid) begin
        check_eq("s_address", s_address, cur.addr);
        check_eq("s_write", 32'(s_write), 32'(cur.wr));
        check_eq("s_read", 32'(s_read), 32'(!cur.wr));
        check_eq("grant", 32'(grant), 32'(cur.gnt));
        if (cur.wr) check_eq("s_data", s_data, cur.data);
        s_ack = (cnt == cur.delay);
        s_dataOut = cur.rdata;
      end
      cnt++;
    end else begin
      if (cnt != 0 && cur_valid) check_eq("s_len", 32'(cnt), 32'(cur.len));
      cnt = 0;
      s_ack = 1'b0;
    end

    if (m0_ack) ack_seen(0);
    if (m1_ack) ack_seen(1);

    if (m0_ack && mreq0.size() != 0) void'(mreq0.pop_front());
    if (m1_ack && mreq1.size() != 0) void'(mreq1.pop_front());
    if (mreq0.size() != 0) begin
      m0_read = mreq0[0].rd; m0_write = mreq0[0].wr;
      m0_address = mreq0[0].addr; m0_data = mreq0[0].data;
    end else begin
      m0_read = 1'b0; m0_write = 1'b0;
    end
    if (mreq1.size() != 0) begin
      m1_read = mreq1[0].rd; m1_write = mreq1[0].wr;
      m1_address = mreq1[0].addr; m1_data = mreq1[0].data;
    end else begin
      m1_read = 1'b0; m1_write = 1'b0;
    end
  end

  // ---------------- sequencing helpers ----------------
  function automatic int pending();
    return mreq0.size() + mreq1.size() + exp_s.size() + exp_m0.size() + exp_m1.size();
  endfunction

  task automatic drain(input string tag);
    int n = 0;
    while (pending() != 0 && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    repeat (2) @(posedge clk);
    #2;
    check_eq(tag, 32'(pending()), 32'd0);
  endtask

  task automatic wait_grant(input logic [1:0] g, input string tag);
    int n = 0;
    while (grant !== g && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    check_eq(tag, 32'(grant), 32'(g));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_s_rw"}, 32'({s_read, s_write}), 32'd0);
    check_eq({tag, "_s_address"}, s_address, 32'd0);
    check_eq({tag, "_s_data"}, s_data, 32'd0);
    check_eq({tag, "_grant"}, 32'(grant), 32'd0);
    check_eq({tag, "_acks"}, 32'({m0_ack, m1_ack}), 32'd0);
    check_eq({tag, "_errs"}, 32'({m0_err, m1_err}), 32'd0);
    check_eq({tag, "_m0_dataOut"}, m0_dataOut, 32'd0);
    check_eq({tag, "_m1_dataOut"}, m1_dataOut, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got no end expected end");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    rst = 1'b1;

    // Both masters request back to back from reset: 0 first, then alternate.
    for (int i = 0; i < 3; i++) begin
      issue(0, 1'b0, 1'b1, 32'h10, 32'hA5, 0, 32'h0000_0100 + 32'(i));
      issue(1, 1'b1, 1'b0, 32'h20, 32'h0, 0, 32'h2000_0000 + 32'(i));
    end
    drain("drain_alternate");

    // Single read, slave acks one cycle late.
    issue(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 1, 32'h1234_5678);
    drain("drain_read");

    // Unanswered write times out, then a normal read follows.
    issue(1, 1'b0, 1'b1, 32'h30, 32'h55, -1, 32'h0);
    issue(1, 1'b1, 1'b0, 32'h34, 32'h0, 2, 32'hCAFE_0001);
    drain("drain_timeout");

    // s_ack on the final watchdog cycle wins.
    issue(0, 1'b1, 1'b0, 32'h40, 32'h0, TIMEOUT - 1, 32'h0BAD_F00D);
    drain("drain_last_cycle_ack");

    // Read and write together is serviced as a write.
    issue(0, 1'b1, 1'b1, 32'h50, 32'h77, 0, 32'h1);
    drain("drain_rw_both");

    // Reset in BUSY abandons the access; master 1 is re-granted afterwards.
    push_req(1, 1'b0, 1'b1, 32'h60, 32'h99);
    push_slave(1, 1'b1, 32'h60, 32'h99, -1, 32'h0);
    wait_grant(2'b10, "busy_grant_m1");
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("mid_reset");
    repeat (2) @(posedge clk);
    #2;
    push_slave(1, 1'b1, 32'h60, 32'h99, 1, 32'h0);
    push_rsp(1, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    wait_grant(2'b10, "regrant_m1");
    issue(0, 1'b1, 1'b0, 32'h70, 32'h0, 0, 32'hFEED_0070);
    drain("drain_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
